// File: rtl/ascii_operand_capture.sv
// Parses "<digits>+<digits>=" from an ASCII char stream into right-aligned packed BCD operands.
// Optional feature: define ASCII_BACKSPACE_EN to give 0x08 backspace editing semantics.
module ascii_operand_capture #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    output logic                  char_ready,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic                  ops_valid,
    input  logic                  ops_ready,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

    typedef enum logic [1:0] {S_A, S_B, S_OUT, S_ERR} state_t;

    state_t          r_state;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [CW-1:0]   r_cnt_a;
    logic [CW-1:0]   r_cnt_b;
    logic            r_ops_valid;
    logic            r_err;

    logic            w_accept;
    logic            w_is_digit;
    logic            w_is_plus;
    logic            w_is_term;
    logic            w_is_clear;
    logic [W-1:0]    w_push_a;
    logic [W-1:0]    w_push_b;

    assign char_ready = (r_state != S_OUT);
    assign w_accept   = char_valid & char_ready;
    assign w_is_digit = (char_in[7:4] == 4'h3) && (char_in[3:0] <= 4'd9);
    assign w_is_plus  = (char_in == 8'h2B);
    assign w_is_term  = (char_in == 8'h3D) || (char_in == 8'h0D);
    assign w_is_clear = (char_in == 8'h1B);
    // Shift rather than slice so DIGITS=1 elaborates without a negative range.
    assign w_push_a   = (r_op_a << 4) | W'(char_in[3:0]);
    assign w_push_b   = (r_op_b << 4) | W'(char_in[3:0]);

    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign ops_valid = r_ops_valid;
    assign err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_A;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
            r_ops_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_A: if (w_accept) begin
                    if (w_is_digit) begin
                        if (r_cnt_a < MAX_CNT) begin
                            r_op_a  <= w_push_a;
                            r_cnt_a <= r_cnt_a + 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end else if (w_is_plus && r_cnt_a != '0) begin
                        r_state <= S_B;
                    end else if (w_is_clear) begin
                        r_op_a  <= '0;
                        r_op_b  <= '0;
                        r_cnt_a <= '0;
                        r_cnt_b <= '0;
`ifdef ASCII_BACKSPACE_EN
                    end else if (char_in == 8'h08) begin
                        if (r_cnt_a != '0) begin
                            r_op_a  <= r_op_a >> 4;
                            r_cnt_a <= r_cnt_a - 1'b1;
                        end
`endif
                    end else begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end
                end
                S_B: if (w_accept) begin
                    if (w_is_digit) begin
                        if (r_cnt_b < MAX_CNT) begin
                            r_op_b  <= w_push_b;
                            r_cnt_b <= r_cnt_b + 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end else if (w_is_term && r_cnt_b != '0) begin
                        r_state     <= S_OUT;
                        r_ops_valid <= 1'b1;
                    end else if (w_is_clear) begin
                        r_state <= S_A;
                        r_op_a  <= '0;
                        r_op_b  <= '0;
                        r_cnt_a <= '0;
                        r_cnt_b <= '0;
`ifdef ASCII_BACKSPACE_EN
                    end else if (char_in == 8'h08) begin
                        // Backspace over an empty B undoes the plus.
                        if (r_cnt_b != '0) begin
                            r_op_b  <= r_op_b >> 4;
                            r_cnt_b <= r_cnt_b - 1'b1;
                        end else begin
                            r_state <= S_A;
                        end
`endif
                    end else begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end
                end
                S_OUT: if (r_ops_valid && ops_ready) begin
                    r_state     <= S_A;
                    r_ops_valid <= 1'b0;
                    r_op_a      <= '0;
                    r_op_b      <= '0;
                    r_cnt_a     <= '0;
                    r_cnt_b     <= '0;
                end
                S_ERR: if (w_accept && w_is_clear) begin
                    r_state <= S_A;
                    r_err   <= 1'b0;
                    r_op_a  <= '0;
                    r_op_b  <= '0;
                    r_cnt_a <= '0;
                    r_cnt_b <= '0;
                end
                default: r_state <= S_A;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_operand_capture.sv
// Directed self-checking bench for ascii_operand_capture (DIGITS=2).
module tb_ascii_operand_capture;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       ops_valid;
    logic       ops_ready = 1'b0;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    ascii_operand_capture #(.DIGITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .ops_valid  (ops_valid),
        .ops_ready  (ops_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        while (!char_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!char_ready) begin
            check_val("send_ready_timeout", 32'(char_ready), 32'd1);
        end else begin
            char_in    = c;
            char_valid = 1'b1;
            @(posedge clk); #1;
            char_valid = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    initial begin
        #12;
        check_val("rst_op_a", 32'(op_a), 32'h0);
        check_val("rst_op_b", 32'(op_b), 32'h0);
        check_val("rst_valid", 32'(ops_valid), 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        check_val("rst_ready", 32'(char_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic expression, immediate transfer
        ops_ready = 1'b1;
        send_str("47+5=");
        check_val("t1_valid", 32'(ops_valid), 32'h1);
        check_val("t1_op_a", 32'(op_a), 32'h47);
        check_val("t1_op_b", 32'(op_b), 32'h05);
        check_val("t1_err", 32'(err), 32'h0);
        check_val("t1_ready_busy", 32'(char_ready), 32'h0);
        @(posedge clk); #1;
        check_val("t1_valid_after", 32'(ops_valid), 32'h0);
        check_val("t1_ready_after", 32'(char_ready), 32'h1);

        // 2: downstream stall with CR terminator
        ops_ready = 1'b0;
        send_str("9+9");
        send(8'h0D);
        for (int i = 0; i < 10; i++) begin
            check_val("t2_valid_hold", 32'(ops_valid), 32'h1);
            check_val("t2_op_a_hold", 32'(op_a), 32'h09);
            check_val("t2_op_b_hold", 32'(op_b), 32'h09);
            check_val("t2_ready_low", 32'(char_ready), 32'h0);
            @(posedge clk); #1;
        end
        ops_ready = 1'b1;
        @(posedge clk); #1;
        check_val("t2_valid_after", 32'(ops_valid), 32'h0);
        check_val("t2_op_a_zero", 32'(op_a), 32'h0);
        check_val("t2_op_b_zero", 32'(op_b), 32'h0);
        check_val("t2_ready_after", 32'(char_ready), 32'h1);

        // 3: operand overflow, sticky error, ESC recovery
        send_str("12");
        check_val("t3_err_pre", 32'(err), 32'h0);
        check_val("t3_op_a_full", 32'(op_a), 32'h12);
        send_str("3");
        check_val("t3_err_set", 32'(err), 32'h1);
        send_str("5");
        check_val("t3_err_sticky", 32'(err), 32'h1);
        send(8'h1B);
        check_val("t3_err_clr", 32'(err), 32'h0);
        check_val("t3_op_a_clr", 32'(op_a), 32'h0);
        send_str("2+2=");
        check_val("t3_valid", 32'(ops_valid), 32'h1);
        check_val("t3_op_a", 32'(op_a), 32'h02);
        check_val("t3_op_b", 32'(op_b), 32'h02);
        @(posedge clk); #1;

        // 4: syntax errors
        send_str("+");
        check_val("t4_plus_first", 32'(err), 32'h1);
        send(8'h1B);
        send_str("3+");
        check_val("t4_no_err_yet", 32'(err), 32'h0);
        send_str("=");
        check_val("t4_empty_b", 32'(err), 32'h1);
        send(8'h1B);
        send_str("a");
        check_val("t4_letter", 32'(err), 32'h1);
        send(8'h1B);
        send(8'h3A);
        check_val("t4_colon", 32'(err), 32'h1);
        send(8'h1B);
        send_str("0=");
        check_val("t4_term_in_a", 32'(err), 32'h1);
        send(8'h1B);
        send_str("5+6+");
        check_val("t4_plus_in_b", 32'(err), 32'h1);
        send(8'h1B);
        check_val("t4_clean", 32'(err), 32'h0);

        // 5: reset mid-expression and while presenting
        send_str("6+1");
        check_val("t5_op_b_partial", 32'(op_b), 32'h01);
        rst = 1'b1; #1;
        check_val("t5_op_a_rst", 32'(op_a), 32'h0);
        check_val("t5_op_b_rst", 32'(op_b), 32'h0);
        check_val("t5_err_rst", 32'(err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ops_ready = 1'b0;
        send_str("1+1=");
        check_val("t5_valid_pend", 32'(ops_valid), 32'h1);
        rst = 1'b1; #1;
        check_val("t5_valid_drop", 32'(ops_valid), 32'h0);
        check_val("t5_ready_rst", 32'(char_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        ops_ready = 1'b1;
        send_str("8+0=");
        check_val("t5_valid", 32'(ops_valid), 32'h1);
        check_val("t5_op_a", 32'(op_a), 32'h08);
        check_val("t5_op_b", 32'(op_b), 32'h00);
        @(posedge clk); #1;

        // 6: backspace
`ifdef ASCII_BACKSPACE_EN
        send_str("47");
        send(8'h08);
        check_val("t6_bs_a", 32'(op_a), 32'h04);
        send_str("+");
        send(8'h08);
        send(8'h08);
        check_val("t6_bs_empty", 32'(op_a), 32'h00);
        send(8'h08);
        check_val("t6_bs_ignored", 32'(err), 32'h0);
        send_str("9+1=");
        check_val("t6_valid", 32'(ops_valid), 32'h1);
        check_val("t6_op_a", 32'(op_a), 32'h09);
        check_val("t6_op_b", 32'(op_b), 32'h01);
        check_val("t6_err", 32'(err), 32'h0);
        @(posedge clk); #1;
`else
        send_str("47");
        send(8'h08);
        check_val("t6_bs_invalid", 32'(err), 32'h1);
        send(8'h1B);
        check_val("t6_err_clr", 32'(err), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ascii_operand_capture.md
# ascii_operand_capture

Front-end stage of the ASCII adder. It accepts a stream of ASCII characters over a valid/ready handshake and parses an expression of the form `<digits>+<digits>=`. It then presents the two operands as right-aligned packed BCD to the downstream adder stage, together with a valid/ready handshake. Syntax errors are flagged and held until the user clears them.

## Interface

**Parameters**
- `DIGITS`, default 2: maximum decimal digits per operand (1–8).

**Ports**
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `char_in`, input, 8: ASCII character.
- `char_valid`, input, 1: `char_in` is valid.
- `char_ready`, output, 1: block can accept a character. A character is accepted when `char_valid & char_ready` is high at a clock edge.
- `op_a`, output, 4*DIGITS: operand A, packed BCD, right-aligned, leading nibbles zero.
- `op_b`, output, 4*DIGITS: operand B, same format as `op_a`.
- `ops_valid`, output, 1: `op_a` and `op_b` are complete and stable.
- `ops_ready`, input, 1: downstream adder takes the operands. Transfer occurs when `ops_valid & ops_ready` is high at a clock edge.
- `err`, output, 1: syntax error latched.

## Operation

**Character classes**
- Digit: `char_in[7:4]==4'h3` and `char_in[3:0]<=9`. Value is `char_in[3:0]`.
- Plus: 0x2B.
- Terminator: 0x3D (`=`) or 0x0D (CR).
- Clear: 0x1B (ESC).
- Everything else is invalid.

**States:** S_A (collect A), S_B (collect B), S_OUT (present), S_ERR.

**S_A**
- Digit with `cnt_a < DIGITS`: `op_a <= {op_a[4*DIGITS-5:0], d}`; `cnt_a++`.
- Digit with `cnt_a == DIGITS`: go to S_ERR.
- Plus with `cnt_a >= 1`: go to S_B.
- Plus with `cnt_a == 0`: go to S_ERR.
- Terminator: go to S_ERR.
- Clear: zero `op_a`, `op_b`, and both counts; stay in S_A.
- Invalid character: go to S_ERR.

**S_B**
- Digit: same as S_A, applied to `op_b`/`cnt_b`.
- Terminator with `cnt_b >= 1`: go to S_OUT.
- Terminator with `cnt_b == 0`: go to S_ERR.
- Plus: go to S_ERR.
- Clear: zero all registers; go to S_A.
- Invalid character: go to S_ERR.

**S_OUT**
- `char_ready=0`; `ops_valid=1`.
- `op_a`/`op_b` are held stable.
- On transfer: zero `op_a`, `op_b`, and both counts; go to S_A.

**S_ERR**
- `err=1`; `char_ready=1`.
- Every character is consumed.
- Only Clear exits: zero all registers, `err` falls, go to S_A.

**Output mapping**
- `char_ready` = state ≠ S_OUT. It is a combinational decode of the state register.
- `ops_valid` = (state == S_OUT), registered.
- `op_a`/`op_b` are also visible during S_A/S_B (partial values), but are only meaningful while `ops_valid` is high.

## Timing

- **Reset:** state S_A; `op_a=0`, `op_b=0`, counts 0, `ops_valid=0`, `err=0`. `char_ready` decodes to 1 from S_A, but no character is accepted while `rst` is high.
- **Reset mid-operation:** any partial expression or pending `ops_valid` is discarded immediately.
- **One character per cycle:** back-to-back acceptance is supported in S_A, S_B, and S_ERR.
- **Latency:** terminator accepted at edge N → `ops_valid` high from edge N to the transfer edge. After the transfer edge, `char_ready` is high in the next cycle.
- **Downstream stall:** `ops_valid` stays high indefinitely while `ops_ready=0`.
- **Error timing:** `err` rises on the edge that accepts the offending character and falls on the edge that accepts ESC.
- **`char_valid` low:** no state change.

## Configuration

- **`ASCII_BACKSPACE_EN` defined:** 0x08 is a recognised character.
  - S_A: if `cnt_a > 0`, `op_a <= op_a >> 4` and `cnt_a--`; if `cnt_a == 0`, the character is ignored.
  - S_B: if `cnt_b > 0`, same on `op_b`; if `cnt_b == 0`, return to S_A (undoes the plus).
  - S_ERR: ignored.
- **`ASCII_BACKSPACE_EN` undefined:** 0x08 is an invalid character and drives S_A/S_B to S_ERR.

## Test plan

All scenarios use `DIGITS=2`.

1. Send "4","7","+","5","=" with `ops_ready=1` → one-cycle `ops_valid` with `op_a=8'h47`, `op_b=8'h05`; `err=0`; `char_ready` high the next cycle.
2. Send "9","+","9",CR with `ops_ready=0` for 10 cycles → `ops_valid` held, `op_a=8'h09`/`op_b=8'h09` stable, `char_ready=0`; when `ops_ready` rises → transfer, then registers are zero.
3. Send "1","2","3" → `err=1` after "3"; send "5" → `err` stays 1; send ESC → `err=0`; then "2","+","2","=" yields `op_a=8'h02`, `op_b=8'h02`.
4. Send "+" first → `err=1`. Separately, send "3","+","=" → `err=1`. Separately, send "a" → `err=1`.
5. Assert `rst` mid-expression after "6","+","1" → all outputs zero. Then "8","+","0","=" → `op_a=8'h08`, `op_b=8'h00`.
6. With `ASCII_BACKSPACE_EN`: send "4","7",BS,"+",BS,BS,"9","+","1","=" → `op_a=8'h09`, `op_b=8'h01`. Without the macro, the first BS sets `err=1`.
